hk_mash_decimator: RTL
======================

# hk_mash_decimator

Sinc³ (third-order CIC) decimator that recovers the fractional control word from the 4-bit signed output stream of the HK-MASH 1-1-1 modulator. It sits at the receive end of the modulator output: in the bench loopback, and in silicon as the frequency-monitor path that checks what the divider actually received. It consumes one modulator sample per valid cycle, decimates by 2^LOG2_DEC, and emits a WIDTH-scaled mean estimate with a one-cycle valid pulse.

## Interface
- WIDTH, 9: fractional word width of the matching modulator; output is scaled by 2^WIDTH.
- LOG2_DEC, 6: log2 of the decimation ratio R. Must satisfy 3*LOG2_DEC >= WIDTH; elaboration error otherwise.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset: one clock; asynchronous, active-low.
- y_i  in  4  signed modulator sample, range -3..+4.
- y_vld_i  in  1  sample strobe; y_i is accepted on each cycle this is high.
- x_o  out  WIDTH+4  signed decimated estimate, mean(y) * 2^WIDTH.
- x_vld_o  out  1  one-cycle pulse when x_o updates.
- settled_o  out  1  high once the output is free of start-up transient.

## Operation
- Internal accumulator width ACC_W = 4 + 3*LOG2_DEC. All integrators and combs are two's-complement ACC_W-bit and wrap modulo 2^ACC_W. Wrap is intended and must not saturate.
- Integrators run at the input rate as a registered chain, advancing only on accepted samples: i1 += sext(y_i); i2 += i1; i3 += i2, each using the previous-cycle value of the stage before it. With y_vld_i low, all integrators and the sample counter hold.
- Sample counter: LOG2_DEC bits, 0..R-1. The block ends when a sample is accepted with cnt == R-1; the counter then wraps to 0.
- Comb section runs at the decimated rate: c1 = i3 - d1, c2 = c1 - d2, c3 = c2 - d3, with d1..d3 holding the previous decimated values of i3, c1, c2.
- Output scaling: x_o = c3 >>> (3*LOG2_DEC - WIDTH) (arithmetic shift), truncated to WIDTH+4 bits. The result is exact for |mean| <= 4.
- Warm-up counter: 2 bits, saturating. It counts x_vld_o pulses after reset. settled_o rises in the same cycle as the 4th pulse and stays high until reset.
- There is no backpressure. A consumer that misses a pulse loses that value; x_o holds until the next pulse.

## Timing
- Reset values: x_o = 0, x_vld_o = 0, settled_o = 0. All integrators, combs, delay registers and counters are 0.
- Cycle N: accept the block-ending sample. Cycle N+1: comb section samples i3, updated to include the chain. Cycle N+2: x_o is registered and x_vld_o pulses for one cycle. Latency is 2 cycles.
- Pulse spacing is R accepted samples. With y_vld_i always high, the period is exactly R cycles.
- A block-ending sample can coincide with an output pulse from the previous block (only possible when R <= 2). Both complete, and the pipeline must not stall.
- If y_vld_i drops between the block end and the pulse, the pulse still occurs at N+2.
- Asserting rst_n mid-block or mid-pipeline clears everything asynchronously. The pending pulse is discarded, the next block starts at cnt = 0, and settled_o drops.

## Configuration
- HK_DEC_ROUND_EN defined: add 2^(3*LOG2_DEC - WIDTH - 1) to c3 before the shift (round half up). When 3*LOG2_DEC == WIDTH, no offset is added.
- Not defined: plain truncation (floor) toward minus infinity.
- Latency and pulse timing are identical in both builds.

## Structure
- Shared package hk_dec_pkg holds:
  - Localparam functions ACC_W(LOG2_DEC) and SHIFT(WIDTH, LOG2_DEC).
  - A typedef for the signed accumulator word.
  - Constant Y_MIN = -3 and Y_MAX = 4.
- Sub-module hk_dec_integrator is one ACC_W-bit enabled accumulator with asynchronous reset. It is instantiated three times. The combs stay inline in the top.

## Test plan
- Reset check: drive rst_n low, then release with y_vld_i = 0 for 200 cycles. Required: x_o = 0, x_vld_o never pulses, settled_o = 0.
- DC decode: defaults, y_i = +1 constant, y_vld_i = 1. Required: pulses every 64 cycles, settled_o rises on the 4th pulse, and x_o = 512 from the 4th pulse onward.
- Negative extreme: y_i = -3 constant. Required: x_o = -1536 once settled, proving correct accumulator wrap. Repeat with y_i = +4, required x_o = 2048.
- Fraction and rounding: alternate y_i 0,1. Required: settled x_o = 256. Then a stream with mean 1/3 (pattern 0,0,1): compare against the reference model, expecting truncation without HK_DEC_ROUND_EN and round-half-up with it.
- Gapped valid: random 50% duty on y_vld_i with y_i = +1. Required: each pulse follows exactly 64 accepted samples, and the pulse arrives 2 cycles after the block-ending sample even if y_vld_i is low in between.
- Loopback: connect the MASH modulator (WIDTH = 9, x = 100) to this block with LOG2_DEC = 8. Required: settled x_o mean over 32 outputs is within ±1 LSB of the modulator's expected mean x*2^WIDTH/(2^WIDTH - A_GAIN) ≈ 100. Then pulse rst_n mid-block and confirm settled_o drops and recovers after 4 pulses.

Source files
------------

// File: rtl/hk_dec_pkg.sv
// Shared sizing helpers and constants for the HK-MASH sinc3 decimator.
package hk_dec_pkg;

  localparam int Y_MIN        = -3;
  localparam int Y_MAX        = 4;
  localparam int DEF_LOG2_DEC = 6;

  function automatic int ACC_W(input int log2_dec);
    return 4 + 3 * log2_dec;
  endfunction

  function automatic int SHIFT(input int width, input int log2_dec);
    return 3 * log2_dec - width;
  endfunction

  // Accumulator word for the default decimation ratio.
  typedef logic signed [ACC_W(DEF_LOG2_DEC)-1:0] acc_t;

endpackage

// File: rtl/hk_dec_integrator.sv
// One enabled wrapping accumulator stage of the sinc3 integrator chain.
module hk_dec_integrator
  import hk_dec_pkg::*;
#(
  parameter int W = ACC_W(DEF_LOG2_DEC)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Modulo 2^W wrap is intentional; the comb section undoes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= q + d;
  end

endmodule

// File: rtl/hk_mash_decimator.sv
// Sinc3 decimator recovering the control word from the HK-MASH 1-1-1 output stream.
// Build option: HK_DEC_ROUND_EN selects round-half-up instead of floor on the output shift.
module hk_mash_decimator
  import hk_dec_pkg::*;
#(
  parameter int WIDTH    = 9,
  parameter int LOG2_DEC = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       y_i,
  input  logic             y_vld_i,
  output logic [WIDTH+3:0] x_o,
  output logic             x_vld_o,
  output logic             settled_o
);

  localparam int AW     = ACC_W(LOG2_DEC);
  localparam int SH     = SHIFT(WIDTH, LOG2_DEC);
  localparam int STAGES = 2;

  if (SH < 0) begin : g_bad_cfg
    $error("hk_mash_decimator: 3*LOG2_DEC must be >= WIDTH");
  end

`ifdef HK_DEC_ROUND_EN
  localparam logic [AW-1:0] RND = (SH > 0) ? (AW'(1) << ((SH > 0) ? SH - 1 : 0)) : '0;
`else
  localparam logic [AW-1:0] RND = '0;
`endif

  logic [LOG2_DEC-1:0]  cnt;
  logic                 blk_end;
  logic [STAGES:1]      vld_pipe;
  logic [2:0][AW-1:0]   din;
  logic [2:0][AW-1:0]   acc;
  logic [AW-1:0]        d1, d2, d3;
  logic [AW-1:0]        c1, c2, c3;
  logic signed [AW-1:0] c3_sh;
  logic [1:0]           wcnt;

  assign blk_end = y_vld_i & (&cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (y_vld_i) cnt <= cnt + 1'b1;
  end

  // Registered chain: each stage adds the previous-cycle value of the one before.
  assign din[0] = {{(AW-4){y_i[3]}}, y_i};
  assign din[1] = acc[0];
  assign din[2] = acc[1];

  hk_dec_integrator #(.W(AW)) u_int [2:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (y_vld_i),
    .d     (din),
    .q     (acc)
  );

  assign c1    = acc[2] - d1;
  assign c2    = c1 - d2;
  assign c3    = c2 - d3;
  assign c3_sh = $signed(c3 + RND) >>> SH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:1], blk_end};
  end

  assign x_vld_o = vld_pipe[STAGES];

  // Comb delays and the output register advance one cycle after the block end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1  <= '0;
      d2  <= '0;
      d3  <= '0;
      x_o <= '0;
    end else if (vld_pipe[1]) begin
      d1  <= acc[2];
      d2  <= c1;
      d3  <= c2;
      x_o <= c3_sh[WIDTH+3:0];
    end
  end

  // The 4th pulse is the first free of the integrator start-up transient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt      <= '0;
      settled_o <= 1'b0;
    end else if (vld_pipe[1]) begin
      if (wcnt != 2'd3) wcnt <= wcnt + 2'd1;
      else              settled_o <= 1'b1;
    end
  end

endmodule
